// File: rtl/ps2_key_tracker.sv
// Purpose: passive PS/2 Set-2 receiver; decodes make/break/extended codes into a 33-key held bitmap.
// Latency: SYNC_STAGES cycles of input sync + 1 cycle from stop-bit sample to o_key/o_code/o_valid.
// Backpressure: none; listen-only, every framed byte is reported as a one-cycle pulse.
module ps2_key_tracker #(
    parameter int TIMEOUT_CYC = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_dat,
    output logic [32:0] o_key,
    output logic [7:0]  o_code,
    output logic        o_valid,
    output logic        o_frame_err
);
    // Depth is clamped so a mis-set parameter can never drop below two flops.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_OVF0 = 8'h00;
    localparam logic [7:0] CODE_OVF1 = 8'hFF;
    localparam logic [5:0] NO_KEY = 6'd63;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_STOP   = 2'd2,
        S_DECODE = 2'd3
    } state_t;

    // Scan code to bitmap position; NO_KEY for anything not on the synth keyboard.
    function automatic logic [5:0] key_index(input logic [7:0] code);
        logic [5:0] idx;
        case (code)
            8'h1A: idx = 6'd0;
            8'h1B: idx = 6'd1;
            8'h22: idx = 6'd2;
            8'h23: idx = 6'd3;
            8'h21: idx = 6'd4;
            8'h2A: idx = 6'd5;
            8'h34: idx = 6'd6;
            8'h32: idx = 6'd7;
            8'h33: idx = 6'd8;
            8'h31: idx = 6'd9;
            8'h3B: idx = 6'd10;
            8'h3A: idx = 6'd11;
            8'h15: idx = 6'd12;
            8'h1E: idx = 6'd13;
            8'h1D: idx = 6'd14;
            8'h26: idx = 6'd15;
            8'h24: idx = 6'd16;
            8'h2D: idx = 6'd17;
            8'h2E: idx = 6'd18;
            8'h2C: idx = 6'd19;
            8'h36: idx = 6'd20;
            8'h35: idx = 6'd21;
            8'h3D: idx = 6'd22;
            8'h3C: idx = 6'd23;
            8'h43: idx = 6'd24;
            8'h46: idx = 6'd25;
            8'h44: idx = 6'd26;
            8'h45: idx = 6'd27;
            8'h4D: idx = 6'd28;
            8'h41: idx = 6'd29;
            8'h4B: idx = 6'd30;
            8'h49: idx = 6'd31;
            8'h29: idx = 6'd32;  // space bar, used as sustain
            default: idx = NO_KEY;
        endcase
        return idx;
    endfunction

    logic [SS-1:0]   clk_sync_q;
    logic [SS-1:0]   dat_sync_q;
    logic            clk_prev_q;
    logic            ps2_clk_s;
    logic            ps2_dat_s;
    logic            fall;

    state_t          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [8:0]      shift_q, shift_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [TW-1:0]   tmo_inc;
    logic            brk_q, brk_d;
    logic            ext_q, ext_d;
    logic [32:0]     key_q, key_d;
    logic [7:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic [7:0]      rx_byte;
    logic [5:0]      key_idx;
    logic            key_hit;
    logic [32:0]     key_bit;

    // Synchronize both lines; idle-high reset value keeps reset release from faking an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SS-2:0], i_ps2_clk};
            dat_sync_q <= {dat_sync_q[SS-2:0], i_ps2_dat};
            clk_prev_q <= clk_sync_q[SS-1];
        end
    end

    assign ps2_clk_s = clk_sync_q[SS-1];
    assign ps2_dat_s = dat_sync_q[SS-1];
    assign fall      = clk_prev_q & ~ps2_clk_s;

    // After 9 shifts, shift_q[7:0] holds D0..D7 and shift_q[8] the parity bit.
    assign rx_byte = shift_q[7:0];
    assign key_idx = key_index(rx_byte);
    assign key_hit = (key_idx != NO_KEY);
    assign key_bit = 33'd1 << key_idx;
    assign tmo_inc = tmo_q + TW'(1);

    // Frame FSM next state, timeout counting and byte decode.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        key_d     = key_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                // A falling edge with data high is a line glitch, not a start bit.
                if (fall && !ps2_dat_s) begin
                    state_d   = S_RECV;
                    bit_cnt_d = '0;
                end
            end

            S_RECV: begin
                if (fall) begin
                    shift_d = {ps2_dat_s, shift_q[8:1]};
                    tmo_d   = '0;
                    if (bit_cnt_q == 4'd8) begin
                        state_d   = S_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_inc == TMO_LAST) begin
                    err_d     = 1'b1;
                    brk_d     = 1'b0;
                    ext_d     = 1'b0;
                    tmo_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            S_STOP: begin
                if (fall) begin
                    tmo_d = '0;
                    if (ps2_dat_s && (^shift_q)) begin
                        // Decode is applied on the stop-bit cycle so the results are
                        // visible while the FSM sits in DECODE, one cycle later.
                        state_d = S_DECODE;
                        code_d  = rx_byte;
                        valid_d = 1'b1;
                        if (rx_byte == CODE_BRK) begin
                            brk_d = 1'b1;
                        end else if (rx_byte == CODE_EXT) begin
                            ext_d = 1'b1;
                        end else if (rx_byte == CODE_OVF0 || rx_byte == CODE_OVF1) begin
                            key_d = '0;
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end else begin
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                            // Extended keys (arrows etc.) never touch the bitmap.
                            if (!ext_q && key_hit) begin
                                if (brk_q) key_d = key_q & ~key_bit;
                                else       key_d = key_q | key_bit;
                            end
                        end
                    end else begin
                        err_d   = 1'b1;
                        brk_d   = 1'b0;
                        ext_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (tmo_inc == TMO_LAST) begin
                    err_d   = 1'b1;
                    brk_d   = 1'b0;
                    ext_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            S_DECODE: begin
                // Single recovery cycle; an edge here cannot occur at legal PS/2 rates.
                tmo_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered output pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            key_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            key_q     <= key_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign o_key       = key_q;
    assign o_code      = code_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed test-plan sequences followed by random scan-code traffic,
// every frame checked against a table-driven keyboard model for latency, pulses, code and bitmap.
module tb_ps2_key_tracker;
    localparam int TIMEOUT_CYC = 100;
    localparam int SYNC_STAGES = 2;
    localparam int LAT = SYNC_STAGES + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [32:0] key;
    logic [7:0]  code;
    logic        valid;
    logic        ferr;

    ps2_key_tracker #(.TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_STAGES(SYNC_STAGES)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_dat  (ps2_dat),
        .o_key      (key),
        .o_code     (code),
        .o_valid    (valid),
        .o_frame_err(ferr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Keyboard model state.
    logic [32:0] m_key = '0;
    logic [7:0]  m_code = '0;
    bit          m_brk = 1'b0;
    bit          m_ext = 1'b0;
    logic [7:0]  key_map [0:32] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32,
                                    8'h33, 8'h31, 8'h3B, 8'h3A, 8'h15, 8'h1E, 8'h1D, 8'h26,
                                    8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C,
                                    8'h43, 8'h46, 8'h44, 8'h45, 8'h4D, 8'h41, 8'h4B, 8'h49,
                                    8'h29};
    logic [7:0]  unmapped [0:4] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h75};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int map_idx(input logic [7:0] b);
        for (int i = 0; i < 33; i++) if (key_map[i] == b) return i;
        return -1;
    endfunction

    task automatic model_good(input logic [7:0] b);
        int idx;
        m_code = b;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'h00 || b == 8'hFF) begin
            m_key = '0; m_brk = 1'b0; m_ext = 1'b0;
        end else begin
            idx = map_idx(b);
            if (!m_ext && idx >= 0) m_key[idx] = !m_brk;
            m_brk = 1'b0; m_ext = 1'b0;
        end
    endtask

    task automatic model_abort();
        m_brk = 1'b0; m_ext = 1'b0;
    endtask

    task automatic model_reset();
        m_key = '0; m_code = '0; m_brk = 1'b0; m_ext = 1'b0;
    endtask

    // Data changes while the PS/2 clock is high; the fall lands 1 time unit after a core posedge.
    task automatic ps2_fall(input logic bitv);
        ps2_dat = bitv;
        repeat ($urandom_range(3, 6)) @(posedge clk);
        #1 ps2_clk = 1'b0;
    endtask

    task automatic ps2_low_then_rise();
        repeat ($urandom_range(4, 7)) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    // Sends one frame and watches the cycles after the stop-bit fall (k = 0 is the first negedge).
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              output int valid_at, output int err_at,
                              output int n_valid, output int n_err, output int n_both);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        valid_at = -1; err_at = -1; n_valid = 0; n_err = 0; n_both = 0;
        for (int i = 0; i < 10; i++) begin
            ps2_fall(bits[i]);
            ps2_low_then_rise();
        end
        ps2_fall(bits[10]);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (valid) begin n_valid++; if (valid_at < 0) valid_at = k; end
            if (ferr) begin n_err++; if (err_at < 0) err_at = k; end
            if (valid && ferr) n_both++;
            if (k == 5) ps2_clk = 1'b1;
        end
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par);
        int va, ea, nv, ne, nb;
        send_frame(b, bad_par, va, ea, nv, ne, nb);
        if (bad_par) begin
            model_abort();
            check({tag, ".err_at"}, 64'(ea), 64'(LAT));
            check({tag, ".valid_cnt"}, 64'(nv), 64'd0);
        end else begin
            model_good(b);
            check({tag, ".valid_at"}, 64'(va), 64'(LAT));
            check({tag, ".valid_cnt"}, 64'(nv), 64'd1);
            check({tag, ".err_cnt"}, 64'(ne), 64'd0);
        end
        check({tag, ".both"}, 64'(nb), 64'd0);
        check({tag, ".code"}, 64'(code), 64'(m_code));
        check({tag, ".key"}, 64'(key), 64'(m_key));
    endtask

    // Sends start plus n data bits, then the line goes quiet.
    task automatic send_partial(input logic [7:0] b, input int n);
        ps2_fall(1'b0);
        ps2_low_then_rise();
        for (int i = 0; i < n; i++) begin
            ps2_fall(b[i]);
            if (i != n - 1) ps2_low_then_rise();
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ea, nv;
        logic [7:0] b;
        int r;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.key", 64'(key), 64'd0);
        check("rst.code", 64'(code), 64'd0);
        check("rst.valid", 64'(valid), 64'd0);
        check("rst.ferr", 64'(ferr), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Make key
        do_frame("make1A", 8'h1A, 1'b0);
        check("make1A.const", 64'(key), 64'h1);

        // Break, sustain and typematic repeat
        do_frame("brkF0", 8'hF0, 1'b0);
        do_frame("brk1A", 8'h1A, 1'b0);
        check("brk1A.const", 64'(key), 64'h0);
        do_frame("make29", 8'h29, 1'b0);
        check("make29.const", 64'(key), 64'h1_0000_0000);
        do_frame("rep29", 8'h29, 1'b0);
        check("rep29.const", 64'(key), 64'h1_0000_0000);
        do_frame("brkF0b", 8'hF0, 1'b0);
        do_frame("brk29", 8'h29, 1'b0);

        // Extended sequence leaves bitmap alone, flags clear afterwards
        do_frame("extE0a", 8'hE0, 1'b0);
        do_frame("ext75a", 8'h75, 1'b0);
        do_frame("extE0b", 8'hE0, 1'b0);
        do_frame("extF0", 8'hF0, 1'b0);
        do_frame("ext75b", 8'h75, 1'b0);
        check("ext.const", 64'(key), 64'h0);
        do_frame("make1B", 8'h1B, 1'b0);
        check("make1B.const", 64'(key), 64'h2);

        // Parity error
        do_frame("par1A", 8'h1A, 1'b1);
        check("par1A.const", 64'(key), 64'h2);
        do_frame("make22", 8'h22, 1'b0);
        check("make22.const", 64'(key), 64'h6);

        // Timeout after 4 data bits
        send_partial(8'h15, 4);
        ea = -1; nv = 0;
        for (int k = 0; k < TIMEOUT_CYC + 20; k++) begin
            @(negedge clk);
            if (ferr && ea < 0) ea = k;
            if (valid) nv++;
            if (k == 5) ps2_clk = 1'b1;
        end
        model_abort();
        check("tmo.err_at", 64'(ea), 64'(SYNC_STAGES + TIMEOUT_CYC));
        check("tmo.valid_cnt", 64'(nv), 64'd0);
        do_frame("make15", 8'h15, 1'b0);
        check("make15.const", 64'(key), 64'h1006);

        // Overflow clears everything
        do_frame("ovf1A", 8'h1A, 1'b0);
        do_frame("ovf29", 8'h29, 1'b0);
        do_frame("ovfFF", 8'hFF, 1'b0);
        check("ovfFF.const", 64'(key), 64'h0);
        do_frame("pre_rst", 8'h23, 1'b0);

        // Asynchronous reset mid-frame
        send_partial(8'h1A, 3);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst.key", 64'(key), 64'd0);
        check("arst.code", 64'(code), 64'd0);
        check("arst.valid", 64'(valid), 64'd0);
        check("arst.ferr", 64'(ferr), 64'd0);
        model_reset();
        ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        do_frame("post_rst", 8'h22, 1'b0);
        check("post_rst.const", 64'(key), 64'h4);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 11);
            if (r <= 4) b = key_map[$urandom_range(0, 32)];
            else if (r <= 6) b = 8'hF0;
            else if (r == 7) b = 8'hE0;
            else if (r == 8) b = unmapped[$urandom_range(0, 4)];
            else if (r == 9 && $urandom_range(0, 2) == 0) b = 8'hFF;
            else b = key_map[$urandom_range(0, 32)];
            do_frame("rand", b, (r == 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
